// File: rtl/apb_master.sv
// APB master: one command at a time, IDLE/SETUP/ACCESS/RESP sequencing.
// Wait-state timeout aborts a stuck ACCESS phase with an error response.
module apb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic [15:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_e;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic        ready_q;
    logic        write_q, write_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        tout_q, tout_d;
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tout_d  = tout_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid && ready_q) begin
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_write ? cmd_wdata : 32'h0;
                    cnt_d   = 16'h0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // pready wins over a timeout on the boundary cycle
                if (pready) begin
                    rdata_d = write_q ? 32'h0 : prdata;
                    err_d   = pslverr;
                    tout_d  = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == TO_LAST) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    tout_d  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 16'h1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= 16'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            tout_q  <= 1'b0;
            cnt_q   <= 16'h0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == IDLE);
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tout_q  <= tout_d;
            cnt_q   <= cnt_d;
        end
    end

    logic on_bus;
    assign on_bus      = (state_q == SETUP) || (state_q == ACCESS);
    assign cmd_ready   = ready_q;
    assign psel        = on_bus;
    assign penable     = (state_q == ACCESS);
    assign pwrite      = on_bus & write_q;
    assign pwdata      = on_bus ? wdata_q : 32'h0;
    assign paddr       = addr_q;
    assign rsp_valid   = (state_q == RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = tout_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: vector table, response scoreboard and
// hand-written stall / reset-in-ACCESS sequences, TIMEOUT_CYCLES=4.
module tb_apb_master;

    logic        pclk = 1'b0;
    logic        preset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_timeout;
    logic [15:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr, busy;

    always #5 pclk = ~pclk;

    apb_master #(.TIMEOUT_CYCLES(4)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .busy(busy)
    );

    // completer model
    int          waits = 0;
    bit          hang = 1'b0;
    bit          slv_err = 1'b0;
    logic [31:0] rd_val = 32'h0;
    int          wcnt = 0;

    assign pready  = psel && penable && !hang && (wcnt >= waits);
    assign prdata  = pready ? rd_val : 32'hDEAD_BEEF;
    assign pslverr = pready && slv_err;

    always @(posedge pclk) begin
        if (psel && penable && !pready) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rsp_t;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          waits;
        bit          hang;
        bit          serr;
        logic [31:0] rdv;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic        exp_to;
        int          exp_pen;
    } vec_t;

    rsp_t sbq[$];
    int   total = 0;
    int   passed = 0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic finish_rsp(input string name);
        int   cyc;
        rsp_t e;
        cyc = 0;
        while (!rsp_valid && cyc < 40) begin
            step();
            cyc++;
        end
        chk({name, " rsp_valid seen"}, 32'(rsp_valid), 32'd1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({name, " rdata"}, rsp_rdata, e.rdata);
            chk({name, " err"}, 32'(rsp_err), 32'(e.err));
            chk({name, " timeout"}, 32'(rsp_timeout), 32'(e.to));
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic run(input vec_t v, input int idx);
        int   cyc, pen;
        bit   stable, bad_pen, setup_ok;
        rsp_t e;
        string n;
        n = $sformatf("v%0d", idx);
        waits   = v.waits;
        hang    = v.hang;
        slv_err = v.serr;
        rd_val  = v.rdv;
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cyc = 0;
        while (!cmd_ready && cyc < 20) begin
            step();
            cyc++;
        end
        chk({n, " cmd_ready"}, 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        cmd_wdata = 32'hFFFF_FFFF;
        e.rdata = v.exp_rd;
        e.err   = v.exp_err;
        e.to    = v.exp_to;
        sbq.push_back(e);
        pen = 0;
        cyc = 0;
        stable = 1'b1;
        bad_pen = 1'b0;
        setup_ok = 1'b0;
        while (!rsp_valid && cyc < 40) begin
            if (psel && !penable)
                setup_ok = (paddr == v.addr) && (pwrite == v.wr) &&
                           (pwdata == (v.wr ? v.wdata : 32'h0));
            if (penable) begin
                pen++;
                if (paddr != v.addr || pwrite != v.wr ||
                    pwdata != (v.wr ? v.wdata : 32'h0))
                    stable = 1'b0;
                if (!psel) bad_pen = 1'b1;
            end
            step();
            cyc++;
        end
        chk({n, " setup signals"}, 32'(setup_ok), 32'd1);
        chk({n, " access stable"}, 32'(stable && !bad_pen), 32'd1);
        chk({n, " penable cycles"}, 32'(pen), 32'(v.exp_pen));
        chk({n, " latency"}, 32'(cyc), 32'(1 + v.exp_pen));
        chk({n, " psel off in RESP"}, 32'({psel, penable, pwrite}), 32'd0);
        chk({n, " paddr kept"}, 32'(paddr), 32'(v.addr));
        finish_rsp(n);
    endtask

    vec_t vt[7];

    initial begin
        rsp_t e1, e2;
        logic [31:0] r;
        logic        re, rt;
        bit          ok, early;
        int          cyc;

        vt[0] = '{1'b1, 16'h0000, 32'h0000_1234, 0, 0, 0, 32'h0,
                  32'h0, 1'b0, 1'b0, 1};
        vt[1] = '{1'b0, 16'h0004, 32'h0, 3, 0, 0, 32'h0000_0007,
                  32'h0000_0007, 1'b0, 1'b0, 4};
        vt[2] = '{1'b0, 16'h0008, 32'h0, 1, 0, 1, 32'h0000_0055,
                  32'h0000_0055, 1'b1, 1'b0, 2};
        vt[3] = '{1'b0, 16'h000C, 32'h0, 0, 1, 0, 32'h1,
                  32'h0, 1'b1, 1'b1, 4};
        vt[4] = '{1'b1, 16'hFFFC, 32'hA5A5_A5A5, 0, 1, 0, 32'h1,
                  32'h0, 1'b1, 1'b1, 4};
        vt[5] = '{1'b1, 16'h0010, 32'h0000_00FF, 2, 0, 1, 32'h9,
                  32'h0, 1'b1, 1'b0, 3};
        vt[6] = '{1'b0, 16'hFFFF, 32'h0, 0, 0, 0, 32'hCAFE_F00D,
                  32'hCAFE_F00D, 1'b0, 1'b0, 1};

        preset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 16'h0;
        cmd_wdata = 32'h0;
        rsp_ready = 1'b0;
        step();
        step();
        chk("rst bus", 32'({psel, penable, pwrite}), 32'd0);
        chk("rst paddr", 32'(paddr), 32'd0);
        chk("rst pwdata", pwdata, 32'd0);
        chk("rst rsp", 32'({rsp_valid, rsp_err, rsp_timeout}), 32'd0);
        chk("rst rdata", rsp_rdata, 32'd0);
        chk("rst busy/ready", 32'({busy, cmd_ready}), 32'd0);
        preset = 1'b0;
        step();
        chk("post-rst cmd_ready", 32'(cmd_ready), 32'd1);

        foreach (vt[i]) run(vt[i], i);

        // response stall with a second command pending
        waits = 0; hang = 0; slv_err = 0; rd_val = 32'h1111_1111;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0020;
        step();
        cmd_write = 1'b1; cmd_addr = 16'h0024; cmd_wdata = 32'h22;
        e1 = '{32'h1111_1111, 1'b0, 1'b0};
        sbq.push_back(e1);
        early = 1'b0;
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            if (cmd_ready) early = 1'b1;
            step();
            cyc++;
        end
        chk("stall rsp_valid", 32'(rsp_valid), 32'd1);
        r = rsp_rdata; re = rsp_err; rt = rsp_timeout;
        ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (!rsp_valid || cmd_ready || rsp_rdata != r ||
                rsp_err != re || rsp_timeout != rt) ok = 1'b0;
            step();
        end
        chk("stall stable", 32'(ok && !early), 32'd1);
        chk("stall rdata", rsp_rdata, sbq[0].rdata);
        rsp_ready = 1'b1;
        void'(sbq.pop_front());
        step();
        rsp_ready = 1'b0;
        chk("stall idle ready", 32'({busy, cmd_ready}), 32'd1);
        e2 = '{32'h0, 1'b0, 1'b0};
        sbq.push_back(e2);
        step();
        cmd_valid = 1'b0;
        chk("second accepted", 32'({psel, penable, pwrite}), 32'b101);
        chk("second paddr", 32'(paddr), 32'h24);
        finish_rsp("second");

        // reset while in ACCESS
        hang = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0030;
        step();
        cmd_valid = 1'b0;
        cyc = 0;
        while (!penable && cyc < 10) begin
            step();
            cyc++;
        end
        chk("mid penable", 32'(penable), 32'd1);
        preset = 1'b1;
        step();
        chk("mid rst bus", 32'({psel, penable, rsp_valid}), 32'd0);
        chk("mid rst ready", 32'(cmd_ready), 32'd0);
        preset = 1'b0;
        step();
        chk("mid rst idle", 32'({busy, cmd_ready}), 32'd1);
        run(vt[6], 7);

        chk("scoreboard empty", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
